// File: rtl/iq_mixer_accumulator.sv
// Quadrature mixer/integrator: multiplies ADC samples by the DCO sin/cos reference
// and sums the products over a programmable N-sample window, one I/Q pair per window.
module iq_mixer_accumulator #(
    parameter int ADC_DATA_WIDTH       = 12,
    parameter int SIN_TABLE_DATA_WIDTH = 13,
    parameter int WINDOW_BITS          = 10,
    parameter int ACC_WIDTH            = 40
) (
    input  logic                                   CLK,
    input  logic                                   RESET_N,
    input  logic                                   CE,
    input  logic signed [ADC_DATA_WIDTH-1:0]       ADC_VALUE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] SIN_VALUE,
    input  logic signed [SIN_TABLE_DATA_WIDTH-1:0] COS_VALUE,
    input  logic        [WINDOW_BITS-1:0]          WINDOW_IN,
    input  logic                                   WINDOW_IN_WE,
    output logic signed [ACC_WIDTH-1:0]            I_OUT,
    output logic signed [ACC_WIDTH-1:0]            Q_OUT,
    output logic                                   OUT_VALID
);
    localparam int PW = ADC_DATA_WIDTH + SIN_TABLE_DATA_WIDTH;

    // Reset asserts asynchronously everywhere; release of the window/accumulator
    // logic is synchronised so counters never leave reset on a partial edge.
    logic [1:0] rst_q;
    logic       rst_sync_n;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) rst_q <= 2'b00;
        else          rst_q <= {rst_q[0], 1'b1};
    end
    assign rst_sync_n = rst_q[1];

    logic [1:0] vld_pipe;
    logic signed [ADC_DATA_WIDTH-1:0]       adc_q;
    logic signed [SIN_TABLE_DATA_WIDTH-1:0] sin_q, cos_q;
    logic signed [PW-1:0]                   prod_i, prod_q;

    // Data path stages run straight off RESET_N so the first edge after
    // release can already capture a sample.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            vld_pipe <= '0;
            adc_q    <= '0;
            sin_q    <= '0;
            cos_q    <= '0;
            prod_i   <= '0;
            prod_q   <= '0;
        end else begin
            vld_pipe[0] <= CE;
            if (CE) begin
                adc_q <= ADC_VALUE;
                sin_q <= SIN_VALUE;
                cos_q <= COS_VALUE;
            end
            vld_pipe[1] <= vld_pipe[0];
            prod_i      <= adc_q * cos_q;
            prod_q      <= adc_q * sin_q;
        end
    end

    logic signed [ACC_WIDTH-1:0] ext_i, ext_q, acc_i, acc_q;
    logic [WINDOW_BITS-1:0]      n_act, n_pend, cnt;
    logic                        last;

    assign ext_i = {{(ACC_WIDTH-PW){prod_i[PW-1]}}, prod_i};
    assign ext_q = {{(ACC_WIDTH-PW){prod_q[PW-1]}}, prod_q};
    assign last  = (cnt == n_act - WINDOW_BITS'(1));

    always_ff @(posedge CLK or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            acc_i     <= '0;
            acc_q     <= '0;
            cnt       <= '0;
            n_act     <= '0;
            n_pend    <= '0;
            I_OUT     <= '0;
            Q_OUT     <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            OUT_VALID <= 1'b0;
            if (WINDOW_IN_WE) n_pend <= WINDOW_IN;
            if (n_act == '0) begin
                // Disabled: products are dropped, a write starts the next window at once.
                acc_i <= '0;
                acc_q <= '0;
                cnt   <= '0;
                if (WINDOW_IN_WE) n_act <= WINDOW_IN;
            end else if (vld_pipe[1]) begin
                if (last) begin
                    I_OUT     <= acc_i + ext_i;
                    Q_OUT     <= acc_q + ext_q;
                    OUT_VALID <= 1'b1;
                    acc_i     <= '0;
                    acc_q     <= '0;
                    cnt       <= '0;
                    n_act     <= WINDOW_IN_WE ? WINDOW_IN : n_pend;
                end else begin
                    acc_i <= acc_i + ext_i;
                    acc_q <= acc_q + ext_q;
                    cnt   <= cnt + WINDOW_BITS'(1);
                end
            end
        end
    end
endmodule

// File: doc/iq_mixer_accumulator.md
# iq_mixer_accumulator

Quadrature demodulator/integrator at the receive end of the sensor excitation chain. It multiplies each signed ADC sample by the SIN/COS reference produced by `sin_cos_dco` and integrates the products over a programmable window of N samples. At the end of each window it emits one I/Q pair. Downstream phase/amplitude logic consumes the pair; the caller aligns the DCO outputs and ADC samples to the same sample instant.

## Interface
- `ADC_DATA_WIDTH`, 12, signed ADC sample width
- `SIN_TABLE_DATA_WIDTH`, 13, signed SIN/COS reference width
- `WINDOW_BITS`, 10, width of the window length register
- `ACC_WIDTH`, 40, signed accumulator/output width; must be >= ADC_DATA_WIDTH+SIN_TABLE_DATA_WIDTH+WINDOW_BITS

- `CLK` in 1, single clock, rising edge
- `RESET_N` in 1, asynchronous, active-low reset
- `CE` in 1, sample strobe; inputs below are sampled only when CE=1
- `ADC_VALUE` in ADC_DATA_WIDTH, signed sample
- `SIN_VALUE` in SIN_TABLE_DATA_WIDTH, signed reference sine
- `COS_VALUE` in SIN_TABLE_DATA_WIDTH, signed reference cosine
- `WINDOW_IN` in WINDOW_BITS, unsigned window length N; 0 = disabled
- `WINDOW_IN_WE` in 1, load strobe for WINDOW_IN, independent of CE
- `I_OUT` out ACC_WIDTH, signed sum of ADC·COS over the last completed window
- `Q_OUT` out ACC_WIDTH, signed sum of ADC·SIN over the last completed window
- `OUT_VALID` out 1, one-cycle pulse when I_OUT/Q_OUT are updated

## Operation
- Stage 1 (input register): on an edge with CE=1, capture ADC/SIN/COS and set the stage-1 valid bit; with CE=0, clear the valid bit.
- Stage 2: register the full-width signed products ADC·COS and ADC·SIN (ADC_DATA_WIDTH+SIN_TABLE_DATA_WIDTH bits) and propagate valid.
- Stage 3: accumulate with sign extension to ACC_WIDTH, using two's-complement wrap and no saturation.
- The pipeline advances every clock; CE qualifies data only and never stalls the pipeline.
- Window control: an active length register `n_act`, a pending register `n_pend`, and a sample counter `cnt` (0..n_act-1) that counts valid stage-2 products.
- States:
  - DISABLED (`n_act`=0): products are discarded, accumulators and `cnt` are held at 0.
  - ACCUM: each valid product is added. When `cnt`=n_act-1:
    - I_OUT/Q_OUT <= accumulator + current product.
    - OUT_VALID=1 for one cycle.
    - Accumulators and `cnt` are cleared.
    - `n_act` <= `n_pend`.
- WINDOW_IN_WE=1 writes `n_pend`.
  - If the block is DISABLED, `n_act` is also loaded on the same edge. A product valid on that edge is not counted; it is discarded.
  - In ACCUM, the new length takes effect only at the next window boundary, so the current window always completes with its original N.
  - If WE coincides with a boundary edge, the written value becomes `n_act` for the window that starts next.
  - Writing 0 disables the block after the current window completes.
- N=1: every valid product produces an OUT_VALID pulse with I/Q equal to that single product.
- I_OUT/Q_OUT hold their value between pulses, including while DISABLED.
- Reset (async, RESET_N=0) clears: all pipeline registers and valid bits, accumulators, `cnt`, `n_act`, `n_pend`, I_OUT=0, Q_OUT=0, OUT_VALID=0. Reset mid-window discards the partial window; no pulse is produced for it.

## Timing
- Latency: if the last sample of a window is captured at edge e (CE=1), OUT_VALID is high and I_OUT/Q_OUT are updated after edge e+2 (3 registered stages, counting e).
- Throughput: one sample per clock; back-to-back windows run with no gap cycle.
- OUT_VALID is never high for two consecutive cycles unless N=1 and CE=1 on consecutive cycles.
- Release of RESET_N is synchronised internally. The first edge after release may already capture a sample.

## Test plan
- Reset: set RESET_N=0 mid-window with N=4 after 2 samples. Required: I_OUT=Q_OUT=0 and OUT_VALID=0 immediately. After release, reload N=4 and apply 4 samples: exactly one pulse, and it excludes the pre-reset samples.
- Basic window: N=4, ADC=100, COS=4095, SIN=0, CE=1 for 4 cycles. Required: a single pulse at edge e_last+2, I_OUT=1638000, Q_OUT=0.
- Sign extremes: N=1, ADC=-2048, SIN=-4096, COS=4095. Required: Q_OUT=8388608, I_OUT=-8386560, with a pulse on every CE cycle.
- CE gaps: N=3, CE on alternate cycles, ADC=1, COS=2, SIN=1. Required: I_OUT=6, Q_OUT=3, and the pulse comes 2 edges after the third accepted sample.
- Deferred length change: N=4, then write N=2 after 2 samples, with a constant ADC=1, COS=1, SIN=1 stream. Required: first pulse I=Q=4, then pulses every 2 samples with I=Q=2.
- Disable: write N=0 mid-window. Required: the current window still pulses. After that, no OUT_VALID for 50 cycles while I_OUT/Q_OUT hold their last values.
